// File: rtl/load_writeback_unit.sv
// load_writeback_unit: single-outstanding load master, memory read to register file writeback.
// Optional LOAD_ALIGN_CHECK_EN routes misaligned LH/LHU/LW requests to the format-error path.
module load_writeback_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rf_data_in,
  output logic [4:0]  rf_Rd,
  output logic        rf_we,
  output logic        busy,
  output logic        timeout_err,
  output logic        fmt_err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic [2:0]       f3_q;
  logic [1:0]       ofs_q;
  logic             bad_req;
  logic [7:0]       byte_d;
  logic [15:0]      half_d;
  logic [31:0]      fmt_d;
  always_comb begin
    bad_req = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LOAD_ALIGN_CHECK_EN
    bad_req = bad_req || (req_funct3[1:0] == 2'b01 && req_addr[0])
                      || (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
`endif
    byte_d = mem_rdata[{ofs_q, 3'b000} +: 8];
    half_d = mem_rdata[{ofs_q[1], 4'b0000} +: 16];
    // funct3[2] selects zero-extension, funct3[1:0] the access size
    fmt_d  = f3_q[1] ? mem_rdata
           : f3_q[0] ? {{16{half_d[15] & ~f3_q[2]}}, half_d}
           : {{24{byte_d[7] & ~f3_q[2]}}, byte_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      f3_q        <= '0;
      ofs_q       <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      rf_data_in  <= '0;
      rf_Rd       <= '0;
      rf_we       <= 1'b0;
      timeout_err <= 1'b0;
      fmt_err     <= 1'b0;
    end else begin
      mem_re      <= 1'b0;
      rf_we       <= 1'b0;
      timeout_err <= 1'b0;
      fmt_err     <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          rd_q      <= req_rd;
          f3_q      <= req_funct3;
          ofs_q     <= req_addr[1:0];
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (bad_req) begin
            state_q <= ERR;
            fmt_err <= 1'b1;
          end else begin
            state_q  <= REQ;
            mem_re   <= 1'b1;
            mem_addr <= {req_addr[31:2], 2'b00};
          end
        end
        REQ: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: if (mem_rvalid) begin
          state_q    <= WB;
          rf_we      <= rd_q != 5'd0;
          rf_Rd      <= rd_q;
          rf_data_in <= fmt_d;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= IDLE;
          timeout_err <= 1'b1;
          req_ready   <= 1'b1;
          busy        <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_writeback_unit.sv
// tb_load_writeback_unit: randomized loads against a lane/extension reference model with a completion scoreboard.
module tb_load_writeback_unit;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        req_ready, mem_re, rf_we, busy, timeout_err, fmt_err;
  logic [31:0] mem_addr, rf_data_in;
  logic [4:0]  rf_Rd;
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } evt_t;
  evt_t        exp_q[$];
  logic [31:0] addr_exp_q[$];
  evt_t        got;
  int          vectors = 0;
  int          errors = 0;
  load_writeback_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_funct3(req_funct3), .req_addr(req_addr),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_data_in(rf_data_in), .rf_Rd(rf_Rd), .rf_we(rf_we), .busy(busy),
    .timeout_err(timeout_err), .fmt_err(fmt_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic legal(input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
`ifdef LOAD_ALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) ok = 1'b0;
    if (f3 == 3'd2 && a % 4 != 0) ok = 1'b0;
`endif
    return ok;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (f3 == 3'd2) return d;
    if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction
  always @(negedge clk) if (!rst) begin
    if (mem_re) begin
      if (addr_exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL mem_re: got unexpected strobe addr %h expected none", mem_addr);
      end else check("mem_addr", mem_addr, addr_exp_q.pop_front());
    end
    if (rf_we || timeout_err || fmt_err) begin
      got.kind = rf_we ? 2'd0 : timeout_err ? 2'd1 : 2'd2;
      got.rd   = rf_we ? rf_Rd : 5'd0;
      got.data = rf_we ? rf_data_in : 32'd0;
      if (exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL completion: got unexpected %h expected none", got);
      end else check("completion", got, exp_q.pop_front());
    end
  end
  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int delay);
    logic ok;
    int   n;
    ok = legal(f3, a);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_rd = rd; req_funct3 = f3; req_addr = a;
    if (!ok) exp_q.push_back({2'd2, 5'd0, 32'd0});
    else begin
      addr_exp_q.push_back({a[31:2], 2'b00});
      if (delay >= TO) exp_q.push_back({2'd1, 5'd0, 32'd0});
      else if (rd != 5'd0) exp_q.push_back({2'd0, rd, ref_load(f3, a, d)});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = $urandom;
    @(negedge clk);
    check("mem_re_latency", mem_re, ok);
    check("busy_not_ready", {busy, req_ready}, 2'b10);
    if (ok && delay < TO) begin
      repeat (delay + 1) @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = d;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      check("rf_we_latency", rf_we, rd != 5'd0);
      @(negedge clk);
      check("ready_latency", {req_ready, busy}, 2'b10);
    end else if (ok) begin
      repeat (TO + 1) @(negedge clk);
      check("timeout_pulse", {timeout_err, rf_we}, 2'b10);
      repeat (2) @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = d;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("return_idle", {req_ready, busy}, 2'b10);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", {req_ready, busy, mem_re, rf_we, timeout_err, fmt_err, rf_Rd, rf_data_in},
          {1'b1, 5'b0, 5'd0, 32'd0});
    rst = 1'b0;
    issue(5'd5, 3'd0, 32'h103, 32'h80FF_1234, 0);
    issue(5'd7, 3'd5, 32'h202, 32'h9ABC_0011, 5);
    issue(5'd0, 3'd2, 32'h300, 32'hDEAD_BEEF, 1);
    issue(5'd3, 3'd2, 32'h400, 32'h1234_5678, TO);
    issue(5'd3, 3'd2, 32'h404, 32'hCAFE_F00D, 0);
    issue(5'd4, 3'd3, 32'h010, 32'h1111_1111, 0);
    issue(5'd6, 3'd1, 32'h001, 32'h1234_8765, 0);
    issue(5'd8, 3'd4, 32'h501, 32'h0000_AB00, TO - 1);
    issue(5'd9, 3'd7, 32'h600, 32'h2222_2222, 0);
    @(negedge clk);
    req_valid = 1'b1; req_rd = 5'd9; req_funct3 = 3'd2; req_addr = 32'h40;
    addr_exp_q.push_back(32'h40);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_wait", {req_ready, busy, mem_re, rf_we, timeout_err, fmt_err, rf_Rd, rf_data_in, mem_addr},
          {1'b1, 5'b0, 5'd0, 32'd0, 32'd0});
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_quiet", {rf_we, busy, req_ready}, 3'b001);
    for (int i = 0; i < 60; i++) begin
      int dly;
      dly = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3))
          : ($urandom_range(0, 4) == 0) ? TO - 1 : int'($urandom_range(0, 4));
      issue(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), $urandom, $urandom, dly);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size() + addr_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
